// File: rtl/param_backup_mem.sv
// Byte-masked burst backing memory: writes land in the array directly, reads flow through a
// fixed-latency pipe into an in-order response FIFO whose space is reserved at command accept.
module param_backup_mem #(
   parameter int DATA_BITS  = 128,
   parameter int ADDR_BITS  = 28,
   parameter int TAG_BITS   = 5,
   parameter int DEPTH_LOG2 = 14,
   parameter int BURST_LEN  = 4,
   parameter int LATENCY    = 4,
   parameter int RESP_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mem_req_valid,
   output logic                   mem_req_ready,
   input  logic                   mem_req_rw,
   input  logic [ADDR_BITS-1:0]   mem_req_addr,
   input  logic [TAG_BITS-1:0]    mem_req_tag,
   input  logic                   mem_req_data_valid,
   output logic                   mem_req_data_ready,
   input  logic [DATA_BITS-1:0]   mem_req_data_bits,
   input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
   output logic                   mem_resp_valid,
   input  logic                   mem_resp_ready,
   output logic [TAG_BITS-1:0]    mem_resp_tag,
   output logic [DATA_BITS-1:0]   mem_resp_data,
   output logic                   addr_err
);
   localparam int BYTES  = DATA_BITS / 8;
   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int BEAT_W = $clog2(BURST_LEN) + 1;
   localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CNT_W  = $clog2(RESP_DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, WDATA, RDISSUE} state_t;

   state_t                state_reg, state_next;
   logic [BEAT_W-1:0]     beat_reg, beat_next;
   logic [DEPTH_LOG2-1:0] base_reg, base_next;
   logic [TAG_BITS-1:0]   tag_reg, tag_next;
   logic [CNT_W-1:0]      used_reg, used_next;
   logic                  addr_err_reg;

   logic                  cmd_ready, cmd_accept, wr_en, rd_en, last_beat, have_credit;
   logic [DEPTH_LOG2-1:0] mem_idx;
   logic [DATA_BITS-1:0]  rd_data;
   logic [DATA_BITS-1:0]  push_data;
   logic                  push, pop;

   // used_reg counts FIFO entries plus beats in the pipe plus beats still to issue
   assign have_credit = (used_reg <= CNT_W'(RESP_DEPTH - BURST_LEN));
   assign last_beat   = (beat_reg == BEAT_W'(BURST_LEN - 1));
   assign mem_idx     = base_reg + DEPTH_LOG2'(beat_reg);
   assign cmd_accept  = cmd_ready && mem_req_valid;

   always_comb begin
      state_next = state_reg;
      beat_next  = beat_reg;
      base_next  = base_reg;
      tag_next   = tag_reg;
      cmd_ready  = 1'b0;
      mem_req_data_ready = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      case (state_reg)
         IDLE: begin
            cmd_ready = reset && have_credit;
            if (cmd_accept) begin
               base_next = mem_req_addr[DEPTH_LOG2-1:0];
               beat_next = '0;
               if (mem_req_rw) begin
                  state_next = WDATA;
               end else begin
                  state_next = RDISSUE;
                  tag_next   = mem_req_tag;
               end
            end
         end
         WDATA: begin
            mem_req_data_ready = 1'b1;
            if (mem_req_data_valid) begin
               wr_en     = 1'b1;
               beat_next = beat_reg + 1'b1;
               if (last_beat) state_next = IDLE;
            end
         end
         RDISSUE: begin
            rd_en     = 1'b1;
            beat_next = beat_reg + 1'b1;
            if (last_beat) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      used_next = used_reg;
      if (cmd_accept && !mem_req_rw) used_next = used_next + CNT_W'(BURST_LEN);
      if (pop) used_next = used_next - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         beat_reg     <= '0;
         base_reg     <= '0;
         tag_reg      <= '0;
         used_reg     <= '0;
         addr_err_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         beat_reg  <= beat_next;
         base_reg  <= base_next;
         tag_reg   <= tag_next;
         used_reg  <= used_next;
         if (cmd_accept && (mem_req_addr[ADDR_BITS-1:DEPTH_LOG2] != '0)) addr_err_reg <= 1'b1;
      end
   end

   // One RAM per byte lane; the lane's registered read is the first pipe stage
   generate
      for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];
         logic [7:0] lane_rd_reg;
         always_ff @(posedge clk) begin
            if (wr_en && mem_req_data_mask[gi]) lane_mem[mem_idx] <= mem_req_data_bits[gi*8 +: 8];
            if (rd_en) lane_rd_reg <= lane_mem[mem_idx];
         end
         assign rd_data[gi*8 +: 8] = lane_rd_reg;
      end
   endgenerate

   logic [LATENCY-1:0]  pipe_valid_reg;
   logic [TAG_BITS-1:0] pipe_tag_reg [LATENCY];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_valid_reg <= '0;
      end else begin
         pipe_valid_reg[0] <= rd_en;
         for (int i = 1; i < LATENCY; i++) pipe_valid_reg[i] <= pipe_valid_reg[i-1];
      end
   end

   always_ff @(posedge clk) begin
      pipe_tag_reg[0] <= tag_reg;
      for (int i = 1; i < LATENCY; i++) pipe_tag_reg[i] <= pipe_tag_reg[i-1];
   end

   generate
      if (LATENCY > 1) begin : g_dly
         logic [DATA_BITS-1:0] dly_reg [LATENCY-1];
         always_ff @(posedge clk) begin
            dly_reg[0] <= rd_data;
            for (int i = 1; i < LATENCY-1; i++) dly_reg[i] <= dly_reg[i-1];
         end
         assign push_data = dly_reg[LATENCY-2];
      end else begin : g_nodly
         assign push_data = rd_data;
      end
   endgenerate

   logic [DATA_BITS-1:0] fifo_data [RESP_DEPTH];
   logic [TAG_BITS-1:0]  fifo_tag  [RESP_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]     fifo_cnt_reg;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign push = pipe_valid_reg[LATENCY-1];
   assign pop  = (fifo_cnt_reg != '0) && mem_resp_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr_reg] <= push_data;
         fifo_tag[wr_ptr_reg]  <= pipe_tag_reg[LATENCY-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         fifo_cnt_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         if (push && !pop)      fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
         else if (!push && pop) fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
      end
   end

   // Head is masked so that stale FIFO contents never show while empty or in reset
   assign mem_req_ready  = cmd_ready;
   assign mem_resp_valid = (fifo_cnt_reg != '0);
   assign mem_resp_data  = mem_resp_valid ? fifo_data[rd_ptr_reg] : '0;
   assign mem_resp_tag   = mem_resp_valid ? fifo_tag[rd_ptr_reg] : '0;
   assign addr_err       = addr_err_reg;

endmodule

// File: tb/tb_param_backup_mem.sv
// Directed and randomized bench for param_backup_mem against a sparse-array memory model
// and an expected-response queue.
module tb_param_backup_mem;
   localparam int DB    = 128;
   localparam int AB    = 28;
   localparam int TB    = 5;
   localparam int DL    = 14;
   localparam int BL    = 4;
   localparam int LAT   = 4;
   localparam int RD    = 8;
   localparam int DEPTH = 1 << DL;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          mem_req_valid = 1'b0;
   logic          mem_req_ready;
   logic          mem_req_rw = 1'b0;
   logic [AB-1:0] mem_req_addr = '0;
   logic [TB-1:0] mem_req_tag = '0;
   logic          mem_req_data_valid = 1'b0;
   logic          mem_req_data_ready;
   logic [DB-1:0] mem_req_data_bits = '0;
   logic [DB/8-1:0] mem_req_data_mask = '0;
   logic          mem_resp_valid;
   logic          mem_resp_ready = 1'b1;
   logic [TB-1:0] mem_resp_tag;
   logic [DB-1:0] mem_resp_data;
   logic          addr_err;

   always #5 clk = ~clk;

   param_backup_mem #(
      .DATA_BITS(DB), .ADDR_BITS(AB), .TAG_BITS(TB), .DEPTH_LOG2(DL),
      .BURST_LEN(BL), .LATENCY(LAT), .RESP_DEPTH(RD)
   ) dut (
      .clk(clk), .reset(reset),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
      .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
      .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
      .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data),
      .addr_err(addr_err)
   );

   typedef struct {
      logic [TB-1:0] tag;
      logic [DB-1:0] data;
   } beat_t;

   beat_t         exp_q[$];
   logic [DB-1:0] ref_mem [int];
   logic [DB-1:0] wdata [BL];
   logic [DB/8-1:0] wmask [BL];
   logic          exp_err = 1'b0;
   bit            rand_ready = 1'b0;
   int            n_assert = 0;
   int            n_fail = 0;

   task automatic check(input string name, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic take_resp();
      beat_t b;
      check("beat_expected", DB'(exp_q.size() != 0), DB'(1));
      if (exp_q.size() != 0) begin
         b = exp_q.pop_front();
         check("resp_data", mem_resp_data, b.data);
         check("resp_tag", DB'(mem_resp_tag), DB'(b.tag));
      end
   endtask

   task automatic tick();
      if (mem_resp_valid && mem_resp_ready) take_resp();
      @(posedge clk);
      #1;
      if (rand_ready) mem_resp_ready = 1'($urandom);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!mem_req_ready && n < 300) begin
         tick();
         n++;
      end
      check("req_ready_wait", DB'(mem_req_ready), DB'(1));
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      check("drain_done", DB'(exp_q.size()), DB'(0));
      tick();
      check("drain_idle_valid", DB'(mem_resp_valid), DB'(0));
   endtask

   function automatic int beat_idx(input logic [AB-1:0] addr, input int b);
      return (int'(addr[DL-1:0]) + b) % DEPTH;
   endfunction

   task automatic do_write(input logic [AB-1:0] addr, input int gap);
      int idx;
      mem_req_data_valid = 1'b0;
      wait_ready();
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b1;
      mem_req_addr  = addr;
      mem_req_tag   = TB'($urandom);
      tick();
      mem_req_valid = 1'b0;
      if ((addr >> DL) != 0) exp_err = 1'b1;
      for (int b = 0; b < BL; b++) begin
         for (int g = 0; g < gap; g++) begin
            mem_req_valid = 1'b1;          // stray read command, must be ignored in WDATA
            mem_req_rw    = 1'b0;
            tick();
            check("wgap_req_ready", DB'(mem_req_ready), DB'(0));
         end
         mem_req_valid = 1'b0;
         check("wdata_ready", DB'(mem_req_data_ready), DB'(1));
         mem_req_data_valid = 1'b1;
         mem_req_data_bits  = wdata[b];
         mem_req_data_mask  = wmask[b];
         tick();
         mem_req_data_valid = 1'b0;
         idx = beat_idx(addr, b);
         for (int k = 0; k < DB/8; k++)
            if (wmask[b][k]) ref_mem[idx][k*8 +: 8] = wdata[b][k*8 +: 8];
      end
      check("wdone_data_ready", DB'(mem_req_data_ready), DB'(0));
   endtask

   task automatic do_read(input logic [AB-1:0] addr, input logic [TB-1:0] tag);
      beat_t e;
      wait_ready();
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b0;
      mem_req_addr  = addr;
      mem_req_tag   = tag;
      // stray write beats, must be ignored outside WDATA
      mem_req_data_valid = 1'b1;
      mem_req_data_bits  = {$urandom, $urandom, $urandom, $urandom};
      mem_req_data_mask  = '1;
      for (int b = 0; b < BL; b++) begin
         e.tag  = tag;
         e.data = ref_mem[beat_idx(addr, b)];
         exp_q.push_back(e);
      end
      if ((addr >> DL) != 0) exp_err = 1'b1;
      tick();
      mem_req_valid = 1'b0;
   endtask

   task automatic fill_full(input logic [7:0] low_base);
      for (int b = 0; b < BL; b++) begin
         wdata[b] = {$urandom, $urandom, $urandom, 24'h0, 8'(low_base + 8'(b))};
         wmask[b] = '1;
      end
   endtask

   initial begin
      int n;
      logic [AB-1:0] a;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", DB'(mem_req_ready), DB'(0));
      check("rst_data_ready", DB'(mem_req_data_ready), DB'(0));
      check("rst_resp_valid", DB'(mem_resp_valid), DB'(0));
      check("rst_resp_tag", DB'(mem_resp_tag), DB'(0));
      check("rst_resp_data", mem_resp_data, DB'(0));
      check("rst_addr_err", DB'(addr_err), DB'(0));
      reset = 1'b1;
      #1;
      check("release_req_ready", DB'(mem_req_ready), DB'(1));

      // write A0..A3 at 0x10, then read back with tag 3
      fill_full(8'hA0);
      do_write(AB'(32'h10), 0);
      do_read(AB'(32'h10), TB'(3));
      n = 0;
      while (!mem_resp_valid && n < 20) begin
         tick();
         n++;
      end
      check("first_latency", DB'(n), DB'(LAT + 1));
      for (int b = 0; b < BL; b++) begin
         check("stream_valid", DB'(mem_resp_valid), DB'(1));
         tick();
      end
      check("burst_done_valid", DB'(mem_resp_valid), DB'(0));
      check("queue_empty", DB'(exp_q.size()), DB'(0));

      // byte-0-only write of all ones
      for (int b = 0; b < BL; b++) begin
         wdata[b] = '1;
         wmask[b] = 16'h0001;
      end
      do_write(AB'(32'h10), 0);
      do_read(AB'(32'h10), TB'($urandom));
      drain();

      // address wrap and upper-bit error
      fill_full(8'h00);
      do_write(AB'(32'h0), 0);
      fill_full(8'hE0);
      do_write(AB'(32'h3FFE), 0);
      do_read(AB'(32'h3FFE), TB'(5));
      drain();
      check("wrap_addr_err", DB'(addr_err), DB'(exp_err));
      do_read(AB'(32'h4000), TB'(6));
      drain();
      check("hi_addr_err", DB'(addr_err), DB'(exp_err));

      // backpressure: two bursts exhaust the credits
      mem_resp_ready = 1'b0;
      do_read(AB'(32'h10), TB'(1));
      do_read(AB'(32'h0), TB'(2));
      mem_req_valid = 1'b1;                 // third command must not be taken
      mem_req_rw    = 1'b0;
      mem_req_addr  = AB'(32'h10);
      mem_req_tag   = TB'(7);
      repeat (10) tick();
      check("bp_req_ready", DB'(mem_req_ready), DB'(0));
      check("bp_resp_valid", DB'(mem_resp_valid), DB'(1));
      mem_req_valid = 1'b0;
      mem_resp_ready = 1'b1;
      drain();
      check("bp_ready_back", DB'(mem_req_ready), DB'(1));

      // write with gaps between data beats
      fill_full(8'h50);
      do_write(AB'(32'h20), 3);
      check("gap_req_ready_after", DB'(mem_req_ready), DB'(1));
      do_read(AB'(32'h20), TB'(4));
      drain();

      // randomized mix inside a preloaded region, random response backpressure
      for (int k = 0; k < 16; k++) begin
         fill_full(8'(k));
         do_write(AB'(32'h100 + 4 * k), 0);
      end
      rand_ready = 1'b1;
      for (int k = 0; k < 24; k++) begin
         a = AB'(32'h100 + $urandom_range(0, 60));
         if ($urandom_range(0, 3) == 0) a[AB-1:DL] = (AB-DL)'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            for (int b = 0; b < BL; b++) begin
               wdata[b] = {$urandom, $urandom, $urandom, $urandom};
               wmask[b] = 16'($urandom);
            end
            do_write(a, $urandom_range(0, 2));
         end else begin
            do_read(a, TB'($urandom));
         end
      end
      rand_ready = 1'b0;
      mem_resp_ready = 1'b1;
      drain();
      check("rand_addr_err", DB'(addr_err), DB'(exp_err));

      // reset during beat 2 of a read
      do_read(AB'(32'h10), TB'(9));
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("midrst_resp_valid", DB'(mem_resp_valid), DB'(0));
      check("midrst_req_ready", DB'(mem_req_ready), DB'(0));
      check("midrst_addr_err", DB'(addr_err), DB'(0));
      exp_q.delete();
      exp_err = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("midrst_release_ready", DB'(mem_req_ready), DB'(1));
      for (int k = 0; k < 12; k++) begin
         check("no_stale_beat", DB'(mem_resp_valid), DB'(0));
         tick();
      end
      do_read(AB'(32'h20), TB'(10));
      do_read(AB'(32'h10), TB'(11));
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
